// File: rtl/rsa_xcel_mont_mont_mulrem.sv
// Iterative radix-2 Montgomery multiplier: ostream_msg = a*b*R^-1 mod n, R = 2^p_nbits.
// Define RSA_XCEL_MONT_MULREM_FINAL_SUB_EN to add the final-subtraction state (result in [0, n)).
module rsa_xcel_mont_mont_mulrem #(
   parameter int p_nbits = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   istream_val,
   output logic                   istream_rdy,
   input  logic [3*p_nbits-1:0]   istream_msg,
   output logic                   ostream_val,
   input  logic                   ostream_rdy,
   output logic [p_nbits-1:0]     ostream_msg
);

   localparam int c_cw = $clog2(p_nbits) + 1;

`ifdef RSA_XCEL_MONT_MULREM_FINAL_SUB_EN
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`endif

   state_t               state;
   state_t               state_next;

   logic [p_nbits+1:0]   s_reg;
   logic [p_nbits-1:0]   a_reg;
   logic [p_nbits-1:0]   b_reg;
   logic [p_nbits-1:0]   n_reg;
   logic [c_cw-1:0]      count;

   logic [p_nbits+1:0]   t_add;
   logic [p_nbits+1:0]   t_sum;
   logic [p_nbits+1:0]   s_next;
   logic                 count_last;

   // One iteration: add b if the current bit of a is set, then add n to make the sum even
   // so the halving is exact. s_reg stays below 2n, so W+2 bits never overflow.
   always_comb begin
      t_add  = s_reg + (a_reg[0] ? {2'b00, b_reg} : '0);
      t_sum  = t_add[0] ? (t_add + {2'b00, n_reg}) : t_add;
      s_next = t_sum >> 1;
   end

   assign count_last = (count == c_cw'(p_nbits - 1));

`ifdef RSA_XCEL_MONT_MULREM_FINAL_SUB_EN
   logic [p_nbits+1:0]   s_sub;
   logic                 s_ge_n;

   always_comb begin
      s_ge_n = (s_reg >= {2'b00, n_reg});
      s_sub  = s_reg - {2'b00, n_reg};
   end
`endif

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Handshake outputs depend only on state, so the partner can build val from rdy freely.
   always_comb begin
      state_next  = state;
      istream_rdy = 1'b0;
      ostream_val = 1'b0;
      case (state)
         IDLE: begin
            istream_rdy = 1'b1;
            if (istream_val)
               state_next = CALC;
         end
         CALC: begin
            if (count_last)
`ifdef RSA_XCEL_MONT_MULREM_FINAL_SUB_EN
               state_next = FIX;
`else
               state_next = DONE;
`endif
         end
`ifdef RSA_XCEL_MONT_MULREM_FINAL_SUB_EN
         FIX: begin
            state_next = DONE;
         end
`endif
         DONE: begin
            ostream_val = 1'b1;
            if (ostream_rdy)
               state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Operands are captured only on the accept edge; a is consumed LSB first.
   always_ff @(posedge clk) begin
      if (reset) begin
         s_reg <= '0;
         a_reg <= '0;
         b_reg <= '0;
         n_reg <= '0;
         count <= '0;
      end
      else begin
         case (state)
            IDLE: begin
               if (istream_val) begin
                  a_reg <= istream_msg[3*p_nbits-1:2*p_nbits];
                  b_reg <= istream_msg[2*p_nbits-1:p_nbits];
                  n_reg <= istream_msg[p_nbits-1:0];
                  s_reg <= '0;
                  count <= '0;
               end
            end
            CALC: begin
               s_reg <= s_next;
               a_reg <= a_reg >> 1;
               count <= count + c_cw'(1);
            end
`ifdef RSA_XCEL_MONT_MULREM_FINAL_SUB_EN
            FIX: begin
               if (s_ge_n)
                  s_reg <= s_sub;
            end
`endif
            default: begin
            end
         endcase
      end
   end

   assign ostream_msg = s_reg[p_nbits-1:0];

endmodule

// File: tb/tb_rsa_xcel_mont_mont_mulrem.sv
// Directed bench for rsa_xcel_mont_mont_mulrem at p_nbits=8 (R=256).
// Latency and the extra reduction vector follow RSA_XCEL_MONT_MULREM_FINAL_SUB_EN.
module tb_rsa_xcel_mont_mont_mulrem;

   localparam int W = 8;
`ifdef RSA_XCEL_MONT_MULREM_FINAL_SUB_EN
   localparam int LAT = W + 1;
`else
   localparam int LAT = W;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic             istream_val;
   logic             istream_rdy;
   logic [3*W-1:0]   istream_msg;
   logic             ostream_val;
   logic             ostream_rdy;
   logic [W-1:0]     ostream_msg;

   int               checks = 0;
   int               failures = 0;
   logic             acceptOk;
   logic             sawVal;
   logic [W-1:0]     heldMsg;

   rsa_xcel_mont_mont_mulrem #(.p_nbits(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .istream_val (istream_val),
      .istream_rdy (istream_rdy),
      .istream_msg (istream_msg),
      .ostream_val (ostream_val),
      .ostream_rdy (ostream_rdy),
      .ostream_msg (ostream_msg)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Presents a request and returns #1 after the edge that accepted it.
   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] n);
      int waitCycles;
      waitCycles  = 0;
      istream_msg = {a, b, n};
      istream_val = 1'b1;
      while (!istream_rdy && waitCycles < 50) begin
         @(posedge clk); #1;
         waitCycles++;
      end
      acceptOk = istream_rdy;
      @(posedge clk); #1;
      istream_val = 1'b0;
      checkOutput("accept", 32'(acceptOk), 32'd1);
   endtask

   // Counts edges from the accept edge until ostream_val, then checks latency and result.
   task automatic waitResult(input string tag, input logic [W-1:0] expMsg);
      int cycles;
      cycles = 0;
      while (!ostream_val && cycles < 100) begin
         @(posedge clk); #1;
         cycles++;
      end
      checkOutput({tag, "_lat"}, 32'(cycles), 32'(LAT));
      checkOutput({tag, "_msg"}, 32'(ostream_msg), 32'(expMsg));
   endtask

   task automatic handshake();
      ostream_rdy = 1'b1;
      @(posedge clk); #1;
      checkOutput("hs_irdy", 32'(istream_rdy), 32'd1);
      checkOutput("hs_oval", 32'(ostream_val), 32'd0);
   endtask

   initial begin
      reset       = 1'b1;
      istream_val = 1'b0;
      istream_msg = '0;
      ostream_rdy = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      $display("[TB] reset state");
      checkOutput("rst_irdy", 32'(istream_rdy), 32'd1);
      checkOutput("rst_oval", 32'(ostream_val), 32'd0);
      checkOutput("rst_omsg", 32'(ostream_msg), 32'd0);
      reset = 1'b0;

      $display("[TB] basic and boundary vectors");
      applyStimulus(8'd1, 8'd1, 8'd13);
      waitResult("rinv13", 8'd3);
      handshake();
      applyStimulus(8'd0, 8'd7, 8'd13);
      waitResult("zero_a", 8'd0);
      handshake();
      applyStimulus(8'd0, 8'd0, 8'd1);
      waitResult("n_one", 8'd0);
      handshake();
      applyStimulus(8'd1, 8'd1, 8'd255);
      waitResult("rinv255", 8'd1);
      handshake();
`ifdef RSA_XCEL_MONT_MULREM_FINAL_SUB_EN
      applyStimulus(8'd254, 8'd254, 8'd255);
      waitResult("final_sub", 8'd1);
      handshake();
`endif

      $display("[TB] backpressure with ignored requests");
      ostream_rdy = 1'b0;
      applyStimulus(8'd9, 8'd5, 8'd13);
      waitResult("ident", 8'd5);
      heldMsg = ostream_msg;
      for (int i = 0; i < 20; i++) begin
         istream_val = 1'b1;
         istream_msg = {8'd3, 8'd4, 8'd13};
         @(posedge clk); #1;
         checkOutput("bp_oval", 32'(ostream_val), 32'd1);
         checkOutput("bp_omsg", 32'(ostream_msg), 32'd5);
         checkOutput("bp_irdy", 32'(istream_rdy), 32'd0);
      end
      checkOutput("bp_held", 32'(heldMsg), 32'd5);
      istream_val = 1'b0;
      ostream_rdy = 1'b1;
      @(posedge clk); #1;
      ostream_rdy = 1'b0;
      checkOutput("pulse_irdy", 32'(istream_rdy), 32'd1);
      checkOutput("pulse_oval", 32'(ostream_val), 32'd0);

      $display("[TB] back-to-back requests");
      ostream_rdy = 1'b1;
      applyStimulus(8'd3, 8'd4, 8'd13);
      istream_msg = {8'd200, 8'd100, 8'd255};
      istream_val = 1'b1;
      waitResult("b2b_first", 8'd10);
      checkOutput("b2b_wait_irdy", 32'(istream_rdy), 32'd0);
      @(posedge clk); #1;
      checkOutput("b2b_idle_irdy", 32'(istream_rdy), 32'd1);
      checkOutput("b2b_idle_oval", 32'(ostream_val), 32'd0);
      @(posedge clk); #1;
      istream_val = 1'b0;
      checkOutput("b2b_accepted", 32'(istream_rdy), 32'd0);
      waitResult("b2b_second", 8'd110);
      @(posedge clk); #1;

      $display("[TB] reset during CALC");
      applyStimulus(8'd9, 8'd5, 8'd13);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checkOutput("midrst_irdy", 32'(istream_rdy), 32'd1);
      checkOutput("midrst_oval", 32'(ostream_val), 32'd0);
      sawVal = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         sawVal = sawVal | ostream_val;
      end
      checkOutput("midrst_noresult", 32'(sawVal), 32'd0);
      applyStimulus(8'd9, 8'd5, 8'd13);
      waitResult("after_rst", 8'd5);
      handshake();

      $display("[TB] reset together with a request");
      reset       = 1'b1;
      istream_val = 1'b1;
      istream_msg = {8'd1, 8'd1, 8'd13};
      @(posedge clk); #1;
      reset       = 1'b0;
      istream_val = 1'b0;
      checkOutput("rstval_irdy", 32'(istream_rdy), 32'd1);
      @(posedge clk); #1;
      checkOutput("rstval_still_idle", 32'(istream_rdy), 32'd1);
      checkOutput("rstval_oval", 32'(ostream_val), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
